wh_bram_writer: RTL and testbench
=================================

// Module: wh_bram_writer
// PURPOSE
//  Write side of the WH BRAM: takes per-node WH rows from the W*H stage and writes them into
//  BRAM port A, split into two ping-pong banks. It tells the aggregator when a subgraph's rows
//  are resident, and which bank and how many nodes they occupy. A bank is reused only after
//  the aggregator reports it has finished reading that bank, so writes overlap aggregation.
// PARAMETERS
//  WH_WIDTH        144  width of one WH row (one BRAM word)
//  WH_2_ADDR_W     9    BRAM port-A address width; MSB = bank select
//  NUM_NODE_WIDTH  9    node-count width; must hold WH_BANK_DEPTH = 2**(WH_2_ADDR_W-1)
// PORTS
//  clk              in   1               clock
//  rst_n            in   1               async reset, ACTIVE-HIGH despite the name
//  wh_valid_i       in   1               WH row valid
//  wh_data_i        in   WH_WIDTH        WH row data
//  wh_last_i        in   1               row is the last node of its subgraph
//  wh_ready_o       out  1               writer can accept a row
//  WH_BRAM_ena      out  1               port-A enable
//  WH_BRAM_wea      out  1               port-A write enable
//  WH_BRAM_addra    out  WH_2_ADDR_W     port-A address {bank, row}
//  WH_BRAM_dina     out  WH_WIDTH        port-A write data
//  aggr_valid_o     out  1               a filled bank is ready for the aggregator
//  aggr_ready_i     in   1               aggregator accepts the announced bank
//  aggr_bank_o      out  1               bank being announced
//  num_of_nodes_o   out  NUM_NODE_WIDTH  rows in the announced bank (1..WH_BANK_DEPTH)
//  aggr_done_i      in   1               1-cycle pulse: aggregator finished the oldest in-use bank
//  ovf_o            out  1               sticky: a subgraph exceeded WH_BANK_DEPTH rows
// BEHAVIOUR
//  Reset (async, rst_n=1): every output is 0; both banks free; wr_bank=0; row_cnt=0; state=IDLE.
//  Reset mid-subgraph discards partial rows and any pending announcement.
//  Write FSM (wh_wr_state_t):
//   - IDLE -> FILL when bank[wr_bank] is free.
//   - FILL: wh_ready_o=1; each accepted row (valid&ready) increments row_cnt.
//   - FILL -> ANNOUNCE on an accepted row with wh_last_i=1, or when row_cnt==WH_BANK_DEPTH-1 is
//     accepted without last. The no-last case force-terminates the subgraph and sets ovf_o.
//     ovf_o stays set until reset.
//   - ANNOUNCE: wh_ready_o=0; bank[wr_bank] marked full; wr_bank toggles.
//   - ANNOUNCE -> IDLE after 1 cycle.
//   - IDLE with the next bank still busy: wh_ready_o=0, hold; input rows stay pending upstream.
//  Write port: registered, 1-cycle latency. A row accepted at cycle T appears at T+1 with
//   ena=wea=1, addra={wr_bank,row_cnt}, dina=data. Otherwise ena=wea=0; addra/dina hold.
//  Announce queue: in-order FIFO of filled banks, depth 2.
//   - aggr_valid_o is high while the FIFO is non-empty; aggr_bank_o/num_of_nodes_o show the head.
//   - For the last row accepted at T, aggr_valid_o rises no earlier than T+2, after its BRAM write.
//   - Payload is stable while valid & !ready. valid&ready pops the head; the bank stays busy.
//  Release:
//   - aggr_done_i frees the oldest handed-off bank, in order. aggr_done_i with no handed-off
//     bank is ignored.
//   - A bank freed at cycle T lets IDLE -> FILL at T+1; wh_ready_o rises at T+1.
//   - aggr_done_i in the same cycle as an ANNOUNCE: both take effect; full/free flags are
//     updated independently per bank.
//  Both banks full: wh_ready_o=0 until a release. Bank index wraps 1 -> 0.
//  row_cnt clears on entry to FILL. A one-row subgraph gives num_of_nodes_o=1.
// STRUCTURE
//  params_pkg:
//   - WH_WIDTH, WH_2_ADDR_W, NUM_NODE_WIDTH
//   - localparam WH_BANK_DEPTH
//   - typedef enum logic[1:0] {IDLE,FILL,ANNOUNCE} wh_wr_state_t
//  Sub-module wh_pingpong_ctrl holds all bank state and the announce queue:
//   - full/handed-off flags per bank, rd pointer, 2-entry announce FIFO
//   - ports: mark_full, bank_in, count_in, aggr_valid/ready/bank/nodes, aggr_done, bank_free[1:0]
//  Top level holds the FSM, row counter, write-port registers and ovf.
// TESTING
//  1. 3 rows A,B,C (last on C), aggr_ready_i=1:
//     -> writes to addra 0,1,2 one cycle after each accept; then aggr_valid_o=1, bank=0, nodes=3.
//  2. Two 4-row subgraphs, no aggr_done_i:
//     -> second goes to addra 256..259 with bank=1; a third subgraph sees wh_ready_o=0 indefinitely.
//     -> one aggr_done_i pulse -> wh_ready_o=1 next cycle; rows written at 0..
//  3. aggr_ready_i=0 for 10 cycles after announce:
//     -> aggr_valid_o, bank and nodes stay stable; pop only on the ready cycle.
//  4. 256 rows with no wh_last_i:
//     -> ovf_o=1, nodes=256, next row starts bank 1 at addr 256.
//  5. rst_n=1 after 2 of 5 rows:
//     -> all outputs 0; the next subgraph writes from addr 0 with nodes counted from 1.
//  6. aggr_done_i in the same cycle as ANNOUNCE of bank 1, with bank 0 in use:
//     -> bank 0 freed, bank 1 full; writer resumes in bank 0 the next cycle.

Source files
------------

// File: rtl/wh_bram_writer_pkg.sv
// Shared widths and types for the WH BRAM write side.
// Bank depth is half the port-A address space; the address MSB selects the bank.
package wh_bram_writer_pkg;

  localparam int WH_WIDTH       = 144;
  localparam int WH_2_ADDR_W    = 9;
  localparam int NUM_NODE_WIDTH = 9;
  localparam int WH_BANK_DEPTH  = 2 ** (WH_2_ADDR_W - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    ANNOUNCE = 2'd2
  } wh_wr_state_t;

endpackage

// File: rtl/wh_bram_writer_pingpong_ctrl.sv
// Ping-pong bank bookkeeping: per-bank full/handed-off flags, in-order release pointer,
// and the 2-entry announce FIFO that presents filled banks to the aggregator.
module wh_pingpong_ctrl
  import wh_bram_writer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mark_full,
  input  logic                      bank_in,
  input  logic [NUM_NODE_WIDTH-1:0] count_in,
  output logic                      aggr_valid,
  input  logic                      aggr_ready,
  output logic                      aggr_bank,
  output logic [NUM_NODE_WIDTH-1:0] aggr_nodes,
  input  logic                      aggr_done,
  output logic [1:0]                bank_free
);

  logic [1:0]                     full_q;
  logic [1:0]                     handed_q;
  logic                           rel_ptr;
  logic [1:0]                     q_bank;
  logic [1:0][NUM_NODE_WIDTH-1:0] q_nodes;
  logic                           q_wr_ptr;
  logic                           q_rd_ptr;
  logic [1:0]                     q_level;
  logic                           pop;
  logic                           release_now;

  assign aggr_valid  = (q_level != 2'd0);
  assign aggr_bank   = q_bank[q_rd_ptr];
  assign aggr_nodes  = q_nodes[q_rd_ptr];
  assign pop         = aggr_valid & aggr_ready;
  // Banks are handed off alternately, so the oldest one is always rel_ptr.
  assign release_now = aggr_done & handed_q[rel_ptr];

  // A release in this cycle is visible immediately so the writer can restart without a bubble.
  always_comb begin
    bank_free = ~full_q;
    if (release_now) bank_free[rel_ptr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      full_q   <= '0;
      handed_q <= '0;
      rel_ptr  <= 1'b0;
      q_bank   <= '0;
      q_nodes  <= '0;
      q_wr_ptr <= 1'b0;
      q_rd_ptr <= 1'b0;
      q_level  <= 2'd0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (mark_full && bank_in == 1'(b))
          full_q[b] <= 1'b1;
        else if (release_now && rel_ptr == 1'(b))
          full_q[b] <= 1'b0;
        if (pop && aggr_bank == 1'(b))
          handed_q[b] <= 1'b1;
        else if (release_now && rel_ptr == 1'(b))
          handed_q[b] <= 1'b0;
      end
      if (release_now) rel_ptr <= ~rel_ptr;
      if (mark_full) begin
        q_bank[q_wr_ptr]  <= bank_in;
        q_nodes[q_wr_ptr] <= count_in;
        q_wr_ptr          <= ~q_wr_ptr;
      end
      if (pop) q_rd_ptr <= ~q_rd_ptr;
      case ({mark_full, pop})
        2'b10:   q_level <= q_level + 2'd1;
        2'b01:   q_level <= q_level - 2'd1;
        default: q_level <= q_level;
      endcase
    end
  end

endmodule

// File: rtl/wh_bram_writer.sv
// WH BRAM write side: streams per-node WH rows into ping-pong banks on port A and
// announces each completed subgraph (bank, node count) to the aggregator.
module wh_bram_writer
  import wh_bram_writer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wh_valid_i,
  input  logic [WH_WIDTH-1:0]       wh_data_i,
  input  logic                      wh_last_i,
  output logic                      wh_ready_o,
  output logic                      WH_BRAM_ena,
  output logic                      WH_BRAM_wea,
  output logic [WH_2_ADDR_W-1:0]    WH_BRAM_addra,
  output logic [WH_WIDTH-1:0]       WH_BRAM_dina,
  output logic                      aggr_valid_o,
  input  logic                      aggr_ready_i,
  output logic                      aggr_bank_o,
  output logic [NUM_NODE_WIDTH-1:0] num_of_nodes_o,
  input  logic                      aggr_done_i,
  output logic                      ovf_o
);

  // state    | meaning
  // IDLE     | waiting for bank[wr_bank] to be free
  // FILL     | accepting rows into bank[wr_bank]
  // ANNOUNCE | push bank to announce queue, flip wr_bank

  localparam logic [NUM_NODE_WIDTH-1:0] LAST_ROW = NUM_NODE_WIDTH'(WH_BANK_DEPTH - 1);

  wh_wr_state_t              state;
  wh_wr_state_t              state_nxt;
  logic [NUM_NODE_WIDTH-1:0] row_cnt;
  logic                      wr_bank;
  logic                      accept;
  logic                      at_last_row;
  logic                      row_end;
  logic                      mark_full;
  logic [1:0]                bank_free;

  assign accept      = wh_valid_i & wh_ready_o;
  assign at_last_row = (row_cnt == LAST_ROW);
  assign row_end     = accept & (wh_last_i | at_last_row);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bank_free[wr_bank]) state_nxt = FILL;
      FILL:     if (row_end) state_nxt = ANNOUNCE;
      ANNOUNCE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wh_ready_o = 1'b0;
    mark_full  = 1'b0;
    case (state)
      FILL:     wh_ready_o = 1'b1;
      ANNOUNCE: mark_full  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      row_cnt       <= '0;
      wr_bank       <= 1'b0;
      ovf_o         <= 1'b0;
      WH_BRAM_ena   <= 1'b0;
      WH_BRAM_wea   <= 1'b0;
      WH_BRAM_addra <= '0;
      WH_BRAM_dina  <= '0;
    end else begin
      if (state == IDLE && state_nxt == FILL)
        row_cnt <= '0;
      else if (accept)
        row_cnt <= row_cnt + NUM_NODE_WIDTH'(1);
      if (mark_full) wr_bank <= ~wr_bank;
      // A full bank without a last marker is cut short; remember it until reset.
      if (accept && !wh_last_i && at_last_row) ovf_o <= 1'b1;
      WH_BRAM_ena <= accept;
      WH_BRAM_wea <= accept;
      if (accept) begin
        WH_BRAM_addra <= {wr_bank, row_cnt[WH_2_ADDR_W-2:0]};
        WH_BRAM_dina  <= wh_data_i;
      end
    end
  end

  wh_pingpong_ctrl u_pingpong (
    .clk        (clk),
    .rst_n      (rst_n),
    .mark_full  (mark_full),
    .bank_in    (wr_bank),
    .count_in   (row_cnt),
    .aggr_valid (aggr_valid_o),
    .aggr_ready (aggr_ready_i),
    .aggr_bank  (aggr_bank_o),
    .aggr_nodes (num_of_nodes_o),
    .aggr_done  (aggr_done_i),
    .bank_free  (bank_free)
  );

endmodule

// File: tb/tb_wh_bram_writer.sv
// Directed bench for wh_bram_writer: a table of subgraphs plus hand-written
// sequences for back-pressure, bank exhaustion, overflow and mid-stream reset.
module tb_wh_bram_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wh_valid;
  logic [143:0] wh_data;
  logic         wh_last;
  logic         wh_ready_o;
  logic         ena, wea;
  logic [8:0]   addra;
  logic [143:0] dina;
  logic         aggr_valid_o;
  logic         aggr_ready;
  logic         aggr_bank_o;
  logic [8:0]   nodes_o;
  logic         aggr_done;
  logic         ovf_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wh_bram_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wh_valid_i     (wh_valid),
    .wh_data_i      (wh_data),
    .wh_last_i      (wh_last),
    .wh_ready_o     (wh_ready_o),
    .WH_BRAM_ena    (ena),
    .WH_BRAM_wea    (wea),
    .WH_BRAM_addra  (addra),
    .WH_BRAM_dina   (dina),
    .aggr_valid_o   (aggr_valid_o),
    .aggr_ready_i   (aggr_ready),
    .aggr_bank_o    (aggr_bank_o),
    .num_of_nodes_o (nodes_o),
    .aggr_done_i    (aggr_done),
    .ovf_o          (ovf_o)
  );

  typedef struct {
    int rows;
    bit use_last;
    bit exp_bank;
    int exp_nodes;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [143:0] mk(input int tag, input int i);
    return {80'hC0FFEE, tag, i};
  endfunction

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    wh_valid = 1'b0; wh_last = 1'b0; wh_data = '0; aggr_done = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {wh_ready_o, ena, wea, addra, aggr_valid_o, aggr_bank_o, nodes_o, ovf_o, dina != '0},
        '0);
    rst_n = 1'b0;
  endtask

  task automatic pulse_done();
    aggr_done = 1'b1;
    @(negedge clk);
    aggr_done = 1'b0;
  endtask

  // Called at a negedge; drives rows and checks each BRAM write one cycle after its accept.
  task automatic send_sg(input int n, input bit use_last, input logic [8:0] base,
                         input int tag, input bit chk_early);
    int i = 0;
    int stall = 0;
    logic [8:0] ea;
    while (i < n) begin
      wh_valid = 1'b1;
      wh_data  = mk(tag, i);
      wh_last  = use_last && (i == n - 1);
      if (wh_ready_o) begin
        @(negedge clk);
        ea = base + 9'(i);
        chk("wr_en", {ena, wea}, 2'b11);
        chk("wr_addr", addra, ea);
        chk("wr_data", dina, mk(tag, i));
        i++;
      end else begin
        stall++;
        if (stall > 50) begin
          checks++; failures++;
          $display("FAIL wr_stall got=ready_low exp=ready_high tag=%0d row=%0d", tag, i);
          break;
        end
        @(negedge clk);
      end
    end
    wh_valid = 1'b0;
    wh_last  = 1'b0;
    if (chk_early) chk("valid_not_early", aggr_valid_o, 1'b0);
  endtask

  task automatic wait_valid(input int max);
    int c = 0;
    while (!aggr_valid_o && c < max) begin
      @(negedge clk);
      c++;
    end
    chk("aggr_valid", aggr_valid_o, 1'b1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int c;
    vecs[0] = '{rows: 3, use_last: 1, exp_bank: 0, exp_nodes: 3};
    vecs[1] = '{rows: 1, use_last: 1, exp_bank: 1, exp_nodes: 1};
    vecs[2] = '{rows: 4, use_last: 1, exp_bank: 0, exp_nodes: 4};
    vecs[3] = '{rows: 2, use_last: 1, exp_bank: 1, exp_nodes: 2};

    aggr_ready = 1'b1;
    do_reset();

    // Table: each subgraph written, announced, popped and released.
    for (int k = 0; k < 4; k++) begin
      send_sg(vecs[k].rows, vecs[k].use_last, {vecs[k].exp_bank, 8'h00}, 10 + k, 1'b1);
      wait_valid(4);
      chk("tbl_bank", aggr_bank_o, vecs[k].exp_bank);
      chk("tbl_nodes", nodes_o, 9'(vecs[k].exp_nodes));
      chk("tbl_ovf", ovf_o, 1'b0);
      @(negedge clk);
      chk("tbl_popped", aggr_valid_o, 1'b0);
      pulse_done();
    end

    // Announcement held under back-pressure.
    aggr_ready = 1'b0;
    send_sg(2, 1'b1, 9'd0, 40, 1'b1);
    wait_valid(4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_payload", {aggr_valid_o, aggr_bank_o, nodes_o}, {1'b1, 1'b0, 9'd2});
    end
    aggr_ready = 1'b1;
    @(negedge clk);
    chk("hold_popped", aggr_valid_o, 1'b0);
    pulse_done();

    // Reset in the middle of a subgraph.
    send_sg(2, 1'b0, 9'd256, 50, 1'b1);
    do_reset();
    send_sg(3, 1'b1, 9'd0, 51, 1'b1);
    wait_valid(4);
    chk("rst_resume", {aggr_bank_o, nodes_o}, {1'b0, 9'd3});

    // Both banks filled; early done ignored; writer blocked until a real release.
    do_reset();
    aggr_ready = 1'b0;
    send_sg(4, 1'b1, 9'd0, 20, 1'b1);
    wait_valid(4);
    chk("two_a", {aggr_bank_o, nodes_o}, {1'b0, 9'd4});
    send_sg(4, 1'b1, 9'd256, 21, 1'b0);
    @(negedge clk);
    pulse_done();
    chk("two_head_a", {aggr_valid_o, aggr_bank_o, nodes_o}, {1'b1, 1'b0, 9'd4});
    aggr_ready = 1'b1;
    @(negedge clk);
    chk("two_head_b", {aggr_valid_o, aggr_bank_o, nodes_o}, {1'b1, 1'b1, 9'd4});
    @(negedge clk);
    chk("two_empty", aggr_valid_o, 1'b0);
    wh_valid = 1'b1; wh_data = mk(22, 0); wh_last = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wh_ready_o || ena) seen++;
    end
    chk("blocked_cycles", 32'(seen), 32'd0);
    pulse_done();
    chk("ready_after_done", wh_ready_o, 1'b1);
    send_sg(3, 1'b1, 9'd0, 22, 1'b1);
    wait_valid(4);
    chk("reuse_bank0", {aggr_bank_o, nodes_o}, {1'b0, 9'd3});
    @(negedge clk);

    // Release coinciding with the announce of bank 1.
    pulse_done();
    send_sg(2, 1'b1, 9'd256, 23, 1'b1);
    aggr_done = 1'b1;
    @(negedge clk);
    aggr_done = 1'b0;
    chk("same_cycle_ann", {aggr_valid_o, aggr_bank_o, nodes_o}, {1'b1, 1'b1, 9'd2});
    c = 0;
    while (!wh_ready_o && c < 3) begin
      @(negedge clk);
      c++;
    end
    chk("same_cycle_ready", wh_ready_o, 1'b1);
    send_sg(1, 1'b1, 9'd0, 24, 1'b1);
    wait_valid(4);
    chk("same_cycle_bank0", {aggr_bank_o, nodes_o}, {1'b0, 9'd1});

    // Overflow: 256 rows without a last marker.
    do_reset();
    send_sg(255, 1'b0, 9'd0, 30, 1'b1);
    chk("ovf_not_yet", {ovf_o, wh_ready_o}, 2'b01);
    send_sg(1, 1'b0, 9'd255, 31, 1'b1);
    chk("ovf_set", ovf_o, 1'b1);
    wait_valid(4);
    chk("ovf_nodes", {aggr_bank_o, nodes_o}, {1'b0, 9'd256});
    @(negedge clk);
    send_sg(1, 1'b1, 9'd256, 32, 1'b1);
    wait_valid(4);
    chk("ovf_next_bank", {aggr_bank_o, nodes_o}, {1'b1, 9'd1});
    chk("ovf_sticky", ovf_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
